// File: rtl/posit8_encoder.sv
// Two-stage valid/ready encoder that turns unpacked posit<8,1> fields into a posit8 word.
// Stage 1 builds the regime/exponent/fraction bit string; stage 2 rounds it (nearest, ties to even) and applies the sign.
module posit8_encoder #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [3:0]        in_regi,
  input  logic              in_expo,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_sticky,
  input  logic              in_zero,
  input  logic              in_nar,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_posit,
  output logic              out_sat
);

  localparam int STR_W = 7 + 1 + FRAC_W + 1;

  logic en1, en2;

  logic             s1_valid_q;
  logic             s1_sign_q, s1_zero_q, s1_nar_q;
  logic             s1_sat_hi_q, s1_sat_lo_q;
  logic [STR_W-1:0] s1_str_q;

  logic             out_valid_q;
  logic [7:0]       out_posit_q;
  logic             out_sat_q;

  logic signed [3:0] k_s;
  logic              sat_hi_d, sat_lo_d;
  logic [3:0]        run_len;
  logic [STR_W-1:0]  tail, reg_pat, s1_str_d;

  logic [6:0] body, body_rnd;
  logic       guard, sticky, rnd;
  logic [7:0] mag, signed_mag, out_posit_d;
  logic       out_sat_d;

  assign en2      = out_ready | ~out_valid_q;
  assign en1      = en2 | ~s1_valid_q;
  assign in_ready = en1;

  assign k_s      = $signed(in_regi);
  assign sat_hi_d = (k_s >= 4'sd6);
  assign sat_lo_d = (k_s <= -4'sd7);
  assign tail     = {in_expo, in_frac, in_sticky, 7'b0};

  // Clamped regimes are built at the largest in-range run length (6); the sat flags override the word later.
  always_comb begin
    run_len = 4'd0;
    reg_pat = '0;
    if (k_s >= 4'sd0) begin
      run_len = sat_hi_d ? 4'd6 : (in_regi + 4'd1);
      reg_pat = ~({STR_W{1'b1}} >> run_len);
    end else begin
      run_len = sat_lo_d ? 4'd6 : (4'd0 - in_regi);
      reg_pat = {1'b1, {(STR_W-1){1'b0}}} >> run_len;
    end
    s1_str_d = reg_pat | (tail >> (run_len + 4'd1));
  end

  assign body     = s1_str_q[STR_W-1 -: 7];
  assign guard    = s1_str_q[STR_W-8];
  assign sticky   = |s1_str_q[STR_W-9:0];
  assign rnd      = guard & (sticky | body[0]);
  assign body_rnd = body + {6'd0, rnd};

  always_comb begin
    if (s1_sat_hi_q)      mag = 8'h7F;
    else if (s1_sat_lo_q) mag = 8'h01;
    else                  mag = {1'b0, body_rnd};
    signed_mag = s1_sign_q ? (~mag + 8'd1) : mag;
    if (s1_nar_q)       out_posit_d = 8'h80;
    else if (s1_zero_q) out_posit_d = 8'h00;
    else                out_posit_d = signed_mag;
    out_sat_d = (s1_sat_hi_q | s1_sat_lo_q) & ~s1_nar_q & ~s1_zero_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_nar_q    <= 1'b0;
      s1_sat_hi_q <= 1'b0;
      s1_sat_lo_q <= 1'b0;
      s1_str_q    <= '0;
      out_valid_q <= 1'b0;
      out_posit_q <= 8'h00;
      out_sat_q   <= 1'b0;
    end else begin
      if (en1) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sign_q   <= in_sign;
          s1_zero_q   <= in_zero;
          s1_nar_q    <= in_nar;
          s1_sat_hi_q <= sat_hi_d;
          s1_sat_lo_q <= sat_lo_d;
          s1_str_q    <= s1_str_d;
        end
      end
      if (en2) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_posit_q <= out_posit_d;
          out_sat_q   <= out_sat_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_posit8_encoder.sv
// Scoreboard bench for posit8_encoder: directed vectors, backpressure, decoder loopback,
// random traffic against a bit-queue reference model, and a mid-stream reset.
module tb_posit8_encoder;
  localparam int FRAC_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic              in_sign;
  logic [3:0]        in_regi;
  logic              in_expo;
  logic [FRAC_W-1:0] in_frac;
  logic              in_sticky, in_zero, in_nar;
  logic              out_valid, out_ready;
  logic [7:0]        out_posit;
  logic              out_sat;

  posit8_encoder #(.FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_regi(in_regi), .in_expo(in_expo), .in_frac(in_frac),
    .in_sticky(in_sticky), .in_zero(in_zero), .in_nar(in_nar),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_posit(out_posit), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] posit;
    logic       sat;
    int         cyc;
  } exp_t;

  typedef struct {
    logic       sgn;
    logic [3:0] k;
    logic       e;
    logic [3:0] f;
    logic       st;
    logic       z;
    logic       n;
    logic [7:0] p;
    logic       sat;
  } vec_t;

  exp_t sb_q[$];
  exp_t push_e, mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic use_dir  = 1'b0;
  logic [7:0] dir_posit = 8'h00;
  logic dir_sat  = 1'b0;
  logic lat_chk  = 1'b0;
  logic saw_stall = 1'b0;
  logic rnd_done = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_posit = 8'h00;
  logic prev_sat = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: spell out the posit bit string as a queue, then round to nearest even.
  function automatic logic [8:0] model(input logic sgn, input logic [3:0] regi, input logic expo,
                                       input logic [FRAC_W-1:0] frac, input logic st,
                                       input logic z, input logic n);
    int k, body, g, s, mag, posit;
    logic sat;
    bit bits[$];
    k   = int'($signed(regi));
    sat = 1'b0;
    if (n) return {1'b0, 8'h80};
    if (z) return 9'h000;
    if (k >= 6) begin
      mag = 127; sat = 1'b1;
    end else if (k <= -7) begin
      mag = 1; sat = 1'b1;
    end else begin
      if (k >= 0) begin
        for (int i = 0; i < k + 1; i++) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      bits.push_back(expo);
      for (int i = FRAC_W - 1; i >= 0; i--) bits.push_back(frac[i]);
      bits.push_back(st);
      while (bits.size() < 9) bits.push_back(1'b0);
      body = 0;
      for (int i = 0; i < 7; i++) body = body * 2 + int'(bits[i]);
      g = int'(bits[7]);
      s = 0;
      for (int i = 8; i < bits.size(); i++) s = s | int'(bits[i]);
      if (g == 1 && (s == 1 || (body % 2) == 1)) body++;
      mag = body;
    end
    posit = sgn ? (256 - mag) % 256 : mag;
    return {sat, 8'(posit)};
  endfunction

  task automatic decode(input logic [7:0] p, output logic sgn, output logic [3:0] regi,
                        output logic expo, output logic [3:0] frac, output logic z, output logic n);
    logic [7:0] mg;
    logic first;
    int idx, run, k;
    sgn = 1'b0; regi = 4'd0; expo = 1'b0; frac = 4'd0; z = 1'b0; n = 1'b0;
    if (p == 8'h00) z = 1'b1;
    else if (p == 8'h80) n = 1'b1;
    else begin
      sgn   = p[7];
      mg    = sgn ? (8'h00 - p) : p;
      first = mg[6];
      idx   = 6;
      run   = 0;
      while (idx >= 0) begin
        if (mg[idx] != first) break;
        run++;
        idx--;
      end
      k    = first ? run - 1 : -run;
      regi = 4'(k);
      idx--;
      if (idx >= 0) expo = mg[idx];
      idx--;
      for (int j = 3; j >= 0; j--) begin
        if (idx >= 0) frac[j] = mg[idx];
        idx--;
      end
    end
  endtask

  always @(posedge clk) cyc++;

  // Expectation side: record every accepted input.
  always @(negedge clk) begin
    if (rst) sb_q.delete();
    else if (in_valid && in_ready) begin
      logic [8:0] m;
      if (use_dir) begin
        push_e.posit = dir_posit;
        push_e.sat   = dir_sat;
      end else begin
        m = model(in_sign, in_regi, in_expo, in_frac, in_sticky, in_zero, in_nar);
        push_e.posit = m[7:0];
        push_e.sat   = m[8];
      end
      push_e.cyc = cyc;
      sb_q.push_back(push_e);
    end
  end

  // Response side: compare every word the DUT hands over.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %02h with nothing outstanding (cycle %0d)", out_posit, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_posit", out_posit, mon_e.posit);
        check("out_sat", out_sat, mon_e.sat);
        if (lat_chk) check("latency", cyc - mon_e.cyc, 2);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && prev_stall) begin
      check("stall_valid", out_valid, 1);
      check("stall_posit", out_posit, prev_posit);
      check("stall_sat", out_sat, prev_sat);
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_posit = out_posit;
    prev_sat   = out_sat;
    if (!rst && in_valid && !in_ready) saw_stall = 1'b1;
  end

  task automatic send(input logic sgn, input logic [3:0] k, input logic e, input logic [3:0] f,
                      input logic st, input logic z, input logic n);
    int t;
    in_sign = sgn; in_regi = k; in_expo = e; in_frac = f;
    in_sticky = st; in_zero = z; in_nar = n;
    in_valid = 1'b1;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: in_ready stuck at %0b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
         ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_outstanding", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  vec_t dv[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_regi = 4'd0; in_expo = 1'b0; in_frac = '0;
    in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_posit", out_posit, 8'h00);
    check("reset_out_sat", out_sat, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // sgn k e f st z n posit sat
    dv.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h40, 1'b0});
    dv.push_back('{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hC0, 1'b0});
    dv.push_back('{1'b0, 4'hF, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 8'h38, 1'b0});
    dv.push_back('{1'b0, 4'h3, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 8'h7A, 1'b0});
    dv.push_back('{1'b0, 4'h3, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 8'h7B, 1'b0});
    dv.push_back('{1'b0, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 8'h7C, 1'b0});
    dv.push_back('{1'b0, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b1});
    dv.push_back('{1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1});
    dv.push_back('{1'b0, 4'h5, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0});
    dv.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0});
    dv.push_back('{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
    dv.push_back('{1'b0, 4'h7, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0});
    dv.push_back('{1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
    dv.push_back('{1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0});

    lat_chk = 1'b1;
    use_dir = 1'b1;
    foreach (dv[i]) begin
      dir_posit = dv[i].p;
      dir_sat   = dv[i].sat;
      send(dv[i].sgn, dv[i].k, dv[i].e, dv[i].f, dv[i].st, dv[i].z, dv[i].n);
    end
    drain();

    // Backpressure: five back-to-back words, sink stalls for four cycles.
    lat_chk = 1'b0;
    use_dir = 1'b0;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_rand();
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("in_ready_dropped", saw_stall, 1);

    // Loopback of every posit8 word through a behavioural decoder.
    lat_chk = 1'b1;
    use_dir = 1'b1;
    for (int p = 0; p < 256; p++) begin
      logic sg, ex, zz, nn;
      logic [3:0] kk, ff;
      logic [7:0] pw;
      pw = 8'(p);
      decode(pw, sg, kk, ex, ff, zz, nn);
      dir_posit = pw;
      dir_sat   = (pw == 8'h7F) || (pw == 8'h81);
      send(sg, kk, ex, ff, 1'b0, zz, nn);
    end
    drain();

    // Random traffic with random sink readiness.
    lat_chk = 1'b0;
    use_dir = 1'b0;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send_rand();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a stream.
    fork
      begin
        for (int i = 0; i < 20; i++) send_rand();
      end
      begin
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_posit", out_posit, 8'h00);
      end
    join
    drain();
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/posit8_encoder.md
Name: posit8_encoder

Overview:
Pipelined encoder that packs unpacked posit<8,1> fields (sign, signed regime k, exponent bit, fraction) into an 8-bit posit word. It is the inverse of the team's posit8 field decoder and sits at the output of the posit arithmetic datapath. Wide fractions are rounded to nearest, ties to even, with posit saturation. It uses a 2-stage valid/ready pipeline.

Parameters:
FRAC_W, 4, fraction input width in bits. Legal range 4..12. At 4 the decoder-to-encoder loopback is lossless.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  input fields valid
in_ready  output  1  encoder accepts the input this cycle
in_sign  input  1  sign of the value (1 = negative)
in_regi  input  4  regime k, two's complement, range -8..7
in_expo  input  1  exponent bit e (es = 1)
in_frac  input  FRAC_W  fraction bits after the hidden 1, MSB first
in_sticky  input  1  OR of any discarded bits below in_frac
in_zero  input  1  value is exactly zero
in_nar  input  1  value is NaR; takes priority over in_zero
out_valid  output  1  out_posit valid
out_ready  input  1  downstream accepts out_posit
out_posit  output  8  encoded posit word
out_sat  output  1  regime was clamped to maxpos/minpos magnitude

Behaviour:
- Reset (rst = 1 at a clock edge): out_valid = 0, out_posit = 0x00, out_sat = 0, and both stage valids clear. Any in-flight data is discarded. in_ready reads 1 in the first cycle after reset.
- Handshake:
  - A transfer occurs when valid and ready are both 1 on a clock edge.
  - Stage enables: en2 = out_ready | ~out_valid; en1 = en2 | ~s1_valid; in_ready = en1 (combinational).
  - While out_valid = 1 and out_ready = 0, out_posit and out_sat hold stable.
- Latency: 2 cycles from input transfer to out_valid, with no bubbles. Throughput is 1 per cycle while out_ready = 1.
- Stage 1 (register on en1):
  - Capture sign, zero, nar.
  - Clamp the regime. k >= 6 sets sat_hi; k <= -7 sets sat_lo.
  - Build the magnitude string: regime bits, then e, then in_frac, then a trailing sticky.
  - Regime bits: for k >= 0, k+1 ones followed by a 0; for k < 0, -k zeros followed by a 1.
- Stage 2 (register on en2):
  - Truncation: body = the top 7 bits of the string. G = the next bit. S = OR of all remaining bits and in_sticky.
  - Rounding: round up iff G & (S | body[0]). Do a 7-bit add.
  - A carry may ripple into e and the regime. This is correct posit behaviour and never exceeds 0x7F, because k >= 6 is already clamped.
- Output word:
  - mag = {1'b0, body}.
  - sat_hi forces mag = 0x7F. sat_lo forces mag = 0x01. out_sat = sat_hi | sat_lo.
  - Rounding never produces 0x00: the minimum body is 0000001.
  - If sign = 1, out_posit = (~mag + 1) mod 256; otherwise out_posit = mag.
  - in_nar forces out_posit = 0x80.
  - Otherwise in_zero forces out_posit = 0x00, regardless of sign.
  - out_sat = 0 for both NaR and zero.
- Widths:
  - The regime is 2..7 bits long.
  - The string is sized 7 + 1 + FRAC_W + 1 so that no bit is lost before rounding.
  - All regime comparisons are signed.
- Simultaneous events:
  - An input transfer and an output transfer in the same cycle both complete.
  - rst overrides any handshake in the same cycle.

Test Plan:
- Basic encodes, FRAC_W = 4, out_ready = 1:
  - k=0, e=0, frac=0000 -> 0x40 after 2 cycles.
  - Same fields with sign=1 -> 0xC0.
  - k=-1, e=1, frac=1000 -> 0x38.
- Rounding, FRAC_W = 4, k=3, e=1:
  - frac=0100, sticky=0 -> 0x7A (tie, stays even).
  - frac=0100, sticky=1 -> 0x7B.
  - frac=1100 -> 0x7C (tie rounds up, carry into regime).
- Saturation:
  - k=7 -> 0x7F, out_sat=1.
  - k=-8, sign=1 -> 0xFF, out_sat=1.
  - k=5, e=1, frac=1111 -> 0x7F, out_sat=0.
- Specials:
  - in_nar=1 with in_zero=1 -> 0x80.
  - in_zero=1, sign=1 -> 0x00.
  - In both cases out_sat=0.
- Backpressure:
  - Stream 5 words with out_ready=0 for cycles 3-6.
  - in_ready drops once both stages are full. out_posit holds stable.
  - All 5 words arrive in order with none lost or duplicated.
- Loopback and reset:
  - Sweep all 256 posit8 words through the decoder into this encoder (FRAC_W=4) -> output equals input.
  - Assert rst mid-stream -> out_valid=0 on the next cycle, and no stale word appears afterwards.
